// File: rtl/i2c_temp_responder.sv
// I2C target for the board temperature sensor (addr DEV_ADDR): pointer write, register reads, open-drain SDA.
// sda_oe follows a pin SCL fall by SYNC_STAGES+2 clks; no backpressure, the bus master owns all timing.
module i2c_temp_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter logic [7:0] ID_VALUE    = 8'hCB,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [12:0] temp_value,
    output logic [7:0]  reg_ptr,
    output logic        busy,
    output logic        xfer_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WDATA, S_TX, S_MACK, S_IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d;
    logic                   sda_hist_q, sda_hist_d;
    logic                   scl_fall_q, scl_fall_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   rw_q, rw_d;
    logic [7:0]             reg_ptr_q, reg_ptr_d;
    logic [12:0]            snap_q, snap_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   busy_q, busy_d;
    logic                   xfer_done_q, xfer_done_d;

    logic       scl_s, sda_s, scl_rise, start_det, stop_det;
    logic [7:0] rx_byte, ptr_inc, tx_load;

    function automatic logic [7:0] reg_read(input logic [7:0] ptr, input logic [12:0] snap);
        case (ptr)
            8'h00:   reg_read = snap[12:5];
            8'h01:   reg_read = {snap[4:0], 3'b000};
            8'h0B:   reg_read = ID_VALUE;
            default: reg_read = 8'h00;
        endcase
    endfunction

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
        scl_rise   = scl_s & ~scl_hist_q;
        // Fall is registered so SDA changes a full clk after SCL is seen low.
        scl_fall_d = ~scl_s & scl_hist_q;
        start_det  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
        stop_det   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
        rx_byte    = {shreg_q[6:0], sda_s};
        ptr_inc    = reg_ptr_q + 8'd1;
        tx_load    = reg_read(reg_ptr_q, snap_q);
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        reg_ptr_d   = reg_ptr_q;
        snap_d      = snap_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        xfer_done_d = 1'b0;
        if (stop_det) begin
            state_d     = S_IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            xfer_done_d = busy_q;
        end else if (start_det) begin
            state_d   = S_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shreg_d = rx_byte;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd8;
                        rw_d      = sda_s;
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                            if (sda_s) snap_d = temp_value;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_PTR, S_WDATA: if (scl_rise) begin
                    shreg_d = rx_byte;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd8;
                        reg_ptr_d = (state_q == S_PTR) ? rx_byte : ptr_inc;
                        state_d   = S_PTR_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                // bit_cnt 8: ACK not yet driven; 9: ACK clock has risen, release on next fall.
                S_ADDR_ACK, S_PTR_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd9;
                    end else if (scl_fall_q) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            bit_cnt_d = 4'd0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d  = S_TX;
                                shreg_d  = tx_load;
                                sda_oe_d = ~tx_load[7];
                            end else begin
                                state_d  = (state_q == S_ADDR_ACK) ? S_PTR : S_WDATA;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                // bit_cnt 0 on a fall means the byte was reloaded after a master ACK.
                S_TX: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_q) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_MACK;
                        end else if (bit_cnt_q != 4'd0) begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_oe_d = ~shreg_q[6];
                        end else begin
                            sda_oe_d = ~shreg_q[7];
                        end
                    end
                end
                S_MACK: if (scl_rise) begin
                    if (!sda_s) begin
                        reg_ptr_d = ptr_inc;
                        shreg_d   = reg_read(ptr_inc, snap_q);
                        bit_cnt_d = 4'd0;
                        state_d   = S_TX;
                    end else begin
                        state_d = S_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_hist_q  <= 1'b1;
            sda_hist_q  <= 1'b1;
            scl_fall_q  <= 1'b0;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= 8'h00;
            rw_q        <= 1'b0;
            reg_ptr_q   <= 8'h00;
            snap_q      <= 13'h0000;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_hist_q  <= scl_hist_d;
            sda_hist_q  <= sda_hist_d;
            scl_fall_q  <= scl_fall_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rw_q        <= rw_d;
            reg_ptr_q   <= reg_ptr_d;
            snap_q      <= snap_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_ptr   = reg_ptr_q;
    assign busy      = busy_q;
    assign xfer_done = xfer_done_q;

endmodule
